// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, late multi-cycle results queue in a small FIFO.
// Optional macro WB_BYPASS_EN: an accepted late result goes straight to the write port when nothing else competes.
module wb_write_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_waddr,
    input  logic [DW-1:0] pipe_wdata,
    output logic          pipe_stall,
    input  logic          mc_valid,
    output logic          mc_ready,
    input  logic [AW-1:0] mc_waddr,
    input  logic [DW-1:0] mc_wdata,
    input  logic [AW-1:0] chk_addr1,
    input  logic [AW-1:0] chk_addr2,
    output logic          chk_busy1,
    output logic          chk_busy2,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          waw_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

    logic [AW-1:0]    fifo_addr [DEPTH];
    logic [DW-1:0]    fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_vld;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;

    logic fifo_empty;
    logic accept;
    logic pipe_sel;
    logic pop;
    logic push;
    logic bypass;
    logic hit1;
    logic hit2;
    logic waw_hit;

    assign fifo_empty = (count == '0);
    assign mc_ready   = (count != FULL_CNT);
    assign accept     = mc_valid && mc_ready;
    // A pipe write offered during the forced-drain slot is ignored.
    assign pipe_sel   = pipe_we && (pipe_waddr != '0) && !pipe_stall;
    assign pop        = !pipe_sel && !fifo_empty;

`ifdef WB_BYPASS_EN
    assign bypass = accept && (mc_waddr != '0) && fifo_empty && !pipe_sel;
`else
    assign bypass = 1'b0;
`endif

    // Writes to r0 are accepted but never queued.
    assign push = accept && (mc_waddr != '0) && !bypass;

    always_comb begin
        hit1    = 1'b0;
        hit2    = 1'b0;
        waw_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_addr[i] == chk_addr1)) hit1 = 1'b1;
            if (fifo_vld[i] && (fifo_addr[i] == chk_addr2)) hit2 = 1'b1;
            if (fifo_vld[i] && (fifo_addr[i] == pipe_waddr)) waw_hit = 1'b1;
        end
        if (push && (mc_waddr == chk_addr1)) hit1 = 1'b1;
        if (push && (mc_waddr == chk_addr2)) hit2 = 1'b1;
    end

    assign chk_busy1 = (chk_addr1 != '0) && hit1;
    assign chk_busy2 = (chk_addr2 != '0) && hit2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fifo_vld <= '0;
        end else begin
            if (pop) begin
                rd_ptr           <= rd_ptr + 1'b1;
                fifo_vld[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr           <= wr_ptr + 1'b1;
                fifo_vld[wr_ptr] <= 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mc_waddr;
            fifo_data[wr_ptr] <= mc_wdata;
        end
    end

    // Long runs of pipe writes with work queued earn the FIFO one guaranteed drain slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            pipe_stall <= 1'b0;
            if (pipe_sel && !fifo_empty) begin
                if (starve_cnt == STARVE_LAST) begin
                    starve_cnt <= '0;
                    pipe_stall <= 1'b1;
                end else begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            waw_err <= 1'b0;
        end else begin
            if (pipe_sel) begin
                we    <= 1'b1;
                waddr <= pipe_waddr;
                wdata <= pipe_wdata;
            end else if (pop) begin
                we    <= 1'b1;
                waddr <= fifo_addr[rd_ptr];
                wdata <= fifo_data[rd_ptr];
            end else if (bypass) begin
                we    <= 1'b1;
                waddr <= mc_waddr;
                wdata <= mc_wdata;
            end else begin
                we <= 1'b0;
            end
            if (pipe_sel && waw_hit) waw_err <= 1'b1;
        end
    end
endmodule
